fp_narrow_convert: RTL

//  Parametrised IEEE-754 narrowing converter (default binary64 -> binary32), next generation of our double->float unit.

---
 rtl/fp_narrow_convert.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/fp_narrow_convert.sv
// fp_narrow_convert: IEEE-754 narrowing converter (default binary64 -> binary32) with four rounding modes.
// Build option DST_SUBNORMAL_EN: produce destination subnormals; when undefined, tiny results flush to signed zero.
module fp_narrow_convert #(
  parameter int SRC_EXP = 11,
  parameter int SRC_MAN = 52,
  parameter int DST_EXP = 8,
  parameter int DST_MAN = 23
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SRC_EXP+SRC_MAN:0] in_data,
  input  logic [1:0]               rounding,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DST_EXP+DST_MAN:0] out_data,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     inexact,
  output logic                     invalid
);
  localparam int DW        = 1 + DST_EXP + DST_MAN;
  localparam int EW        = SRC_EXP + 1;
  localparam int SIG_W     = SRC_MAN + 1;
  localparam int G_IDX     = SRC_MAN - DST_MAN - 1;
  localparam int BIAS_DIFF = (2**(SRC_EXP-1) - 1) - (2**(DST_EXP-1) - 1);
  localparam int E_MAX     = 2**DST_EXP - 1;
  localparam int SH_MAX    = DST_MAN + 2;
  localparam int SH_W      = $clog2(SH_MAX + 1);

  typedef enum logic [1:0] {IDLE, CLASSIFY, ROUND, HOLD} state_t;
  state_t state_reg, state_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CLASSIFY;
      end
      CLASSIFY: state_next = ROUND;
      ROUND:    state_next = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  logic               sign_reg;
  logic [SRC_EXP-1:0] exp_reg;
  logic [SRC_MAN-1:0] man_reg;
  logic [1:0]         rm_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sign_reg <= 1'b0;
      exp_reg  <= '0;
      man_reg  <= '0;
      rm_reg   <= 2'b00;
    end else if (state_reg == IDLE && in_valid) begin
      {sign_reg, exp_reg, man_reg} <= in_data;
      rm_reg <= rounding;
    end
  end

  // Classification and alignment of the captured operand
  logic                 exp_ones, exp_zero, man_zero;
  logic [SRC_EXP-1:0]   exp_eff;
  logic signed [EW-1:0] e_cls;
  logic                 tiny_cls, flush_cls, lost_bits;
  logic [SIG_W-1:0]     sig_full, sig_shift;
  logic [SH_W-1:0]      sh_amt;
  logic [DW-1:0]        special_data;
  logic                 special_cls, invalid_cls;

  assign exp_ones = &exp_reg;
  assign exp_zero = ~|exp_reg;
  assign man_zero = ~|man_reg;
  // Source subnormals share the minimum exponent of normals, just without the hidden bit.
  assign exp_eff  = exp_zero ? SRC_EXP'(1) : exp_reg;
  assign e_cls    = $signed({1'b0, exp_eff}) - $signed(EW'(BIAS_DIFF));
  assign tiny_cls = e_cls[EW-1] | (e_cls == '0);
  assign sig_full = {~exp_zero, man_reg};

`ifdef DST_SUBNORMAL_EN
  logic [EW-1:0] sh_wide;
  assign sh_wide   = EW'(1) - $unsigned(e_cls);
  assign sh_amt    = !tiny_cls ? '0 :
                     (sh_wide > EW'(SH_MAX)) ? SH_W'(SH_MAX) : sh_wide[SH_W-1:0];
  assign flush_cls = 1'b0;
`else
  assign sh_amt    = '0;
  assign flush_cls = tiny_cls;
`endif

  assign sig_shift = sig_full >> sh_amt;
  assign lost_bits = |(sig_full & ~({SIG_W{1'b1}} << sh_amt));

  always_comb begin
    special_data = '0;
    special_cls  = 1'b0;
    invalid_cls  = 1'b0;
    if (exp_zero && man_zero) begin
      special_cls  = 1'b1;
      special_data = {sign_reg, {(DW-1){1'b0}}};
    end else if (exp_ones) begin
      special_cls = 1'b1;
      if (man_zero) begin
        special_data = {sign_reg, {DST_EXP{1'b1}}, {DST_MAN{1'b0}}};
      end else begin
        special_data = {sign_reg, {DST_EXP{1'b1}}, 1'b1, man_reg[SRC_MAN-2 -: DST_MAN-1]};
        invalid_cls  = ~man_reg[SRC_MAN-1];
      end
    end
  end

  logic                 special_reg, invalid_cls_reg, flush_reg, tiny_reg;
  logic [DW-1:0]        special_data_reg;
  logic signed [EW-1:0] e_reg;
  logic [DST_MAN-1:0]   kept_reg;
  logic                 guard_reg, sticky_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      special_reg      <= 1'b0;
      invalid_cls_reg  <= 1'b0;
      flush_reg        <= 1'b0;
      tiny_reg         <= 1'b0;
      special_data_reg <= '0;
      e_reg            <= '0;
      kept_reg         <= '0;
      guard_reg        <= 1'b0;
      sticky_reg       <= 1'b0;
    end else if (state_reg == CLASSIFY) begin
      special_reg      <= special_cls;
      invalid_cls_reg  <= invalid_cls;
      flush_reg        <= flush_cls;
      tiny_reg         <= tiny_cls;
      special_data_reg <= special_data;
      e_reg            <= e_cls;
      kept_reg         <= sig_shift[SRC_MAN-1 -: DST_MAN];
      guard_reg        <= sig_shift[G_IDX];
      sticky_reg       <= (|sig_shift[G_IDX-1:0]) | lost_bits;
    end
  end

  // Rounding, overflow saturation and result assembly
  logic                 round_inc, carry, rnd_inexact, ovf, to_inf;
  logic [DST_MAN-1:0]   man_sum;
  logic signed [EW-1:0] exp_post;
  logic [DW-1:0]        res_data;
  logic                 res_ovf, res_unf, res_inx, res_inv;

  always_comb begin
    rnd_inexact = guard_reg | sticky_reg;
    case (rm_reg)
      2'b01:   round_inc = ~sign_reg & rnd_inexact;
      2'b10:   round_inc = sign_reg & rnd_inexact;
      2'b11:   round_inc = guard_reg & (sticky_reg | kept_reg[0]);
      default: round_inc = 1'b0;
    endcase
    {carry, man_sum} = {1'b0, kept_reg} + (DST_MAN+1)'(round_inc);
    // A tiny result lives at exponent field 0; a carry lifts it to the smallest normal.
    exp_post = (tiny_reg ? '0 : e_reg) + $signed(EW'(carry));
    ovf      = !tiny_reg && (exp_post >= $signed(EW'(E_MAX)));
    to_inf   = (rm_reg == 2'b11) || (rm_reg == 2'b01 && !sign_reg) || (rm_reg == 2'b10 && sign_reg);

    res_data = {sign_reg, exp_post[DST_EXP-1:0], man_sum};
    res_ovf  = 1'b0;
    res_unf  = tiny_reg & rnd_inexact;
    res_inx  = rnd_inexact;
    res_inv  = 1'b0;
    if (special_reg) begin
      res_data = special_data_reg;
      res_unf  = 1'b0;
      res_inx  = 1'b0;
      res_inv  = invalid_cls_reg;
    end else if (flush_reg) begin
      res_data = {sign_reg, {(DW-1){1'b0}}};
      res_unf  = 1'b1;
      res_inx  = 1'b1;
    end else if (ovf) begin
      res_inx = 1'b1;
      res_unf = 1'b0;
      if (to_inf) begin
        res_data = {sign_reg, {DST_EXP{1'b1}}, {DST_MAN{1'b0}}};
        res_ovf  = 1'b1;
      end else begin
        res_data = {sign_reg, DST_EXP'(E_MAX - 1), {DST_MAN{1'b1}}};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
      invalid   <= 1'b0;
    end else if (state_reg == ROUND) begin
      out_data  <= res_data;
      overflow  <= res_ovf;
      underflow <= res_unf;
      inexact   <= res_inx;
      invalid   <= res_inv;
    end
  end
endmodule
